spi_burst_memory: RTL
=====================

SPI_BURST_MEMORY -- requirements
Module: spi_burst_memory

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, word address width; memory depth SHALL be 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8, bits per memory word and per SPI data frame.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flops per SPI input (minimum 2).
REQ-004 clk  input  1  system clock; the block SHALL use this single clock for all sequential logic.
REQ-005 reset  input  1  reset, synchronous to clk and active-high.
REQ-006 sclk_pin  input  1  SPI clock, asynchronous to clk; mode 0 (CPOL=0, CPHA=0).
REQ-007 cs_pin  input  1  SPI chip select, active-low, asynchronous.
REQ-008 mosi_pin  input  1  SPI master-out data, asynchronous.
REQ-009 miso_pin  output  1  SPI master-in data, registered.
REQ-010 miso_oe  output  1  MISO drive enable; the external pad is driven only when high.
REQ-011 leds  output  4  debug: [0] busy (state != IDLE), [1] read burst, [2] write burst, [3] toggles on every memory write commit.

Function
REQ-012 Each SPI input SHALL pass through SYNC_STAGES flops plus one edge-detect flop; rise and fall SHALL be single-clk pulses.
REQ-013 Timing contract: each SCLK high and low phase SHALL last at least SYNC_STAGES+3 clk cycles; behaviour outside this contract is undefined.
REQ-014 States SHALL be IDLE, CMD, RD_LOAD, RD_SHIFT, WR_SHIFT and WR_COMMIT.
REQ-015 IDLE -> CMD on synchronized CS fall; the bit counter SHALL clear and miso_oe SHALL stay low.
REQ-016 CMD: on each synchronized SCLK rise, MOSI is shifted in MSB first. After ADDR_WIDTH+1 bits the frame is {address, R/W} with R/W last (1 = read); the address loads into the address counter.
REQ-017 CMD with R/W=1 -> RD_LOAD. CMD with R/W=0 -> WR_SHIFT.
REQ-018 RD_LOAD: synchronous memory read of mem[addr] (1 clk), loaded into the shift register on the next clk; then -> RD_SHIFT. The whole step SHALL finish before the next SCLK fall.
REQ-019 RD_SHIFT: miso_oe SHALL be high. On each SCLK fall, miso_pin SHALL take the current shift-register MSB and the register SHALL shift left.
REQ-020 In RD_SHIFT, after DATA_WIDTH SCLK rises the address counter SHALL increment modulo 2**ADDR_WIDTH and the state SHALL return to RD_LOAD (burst read).
REQ-021 WR_SHIFT: on each SCLK rise, MOSI is shifted in MSB first. After DATA_WIDTH bits -> WR_COMMIT.
REQ-022 WR_COMMIT: mem[addr] <= received word in exactly one clk; the address counter increments modulo 2**ADDR_WIDTH; leds[3] toggles; then -> WR_SHIFT (burst write).
REQ-023 A synchronized CS rise in any state SHALL force IDLE on the next clk, with miso_oe=0 and the bit counter cleared. A partial write word SHALL be discarded and memory left unchanged.
REQ-024 If a CS rise and an SCLK edge are detected in the same clk, the CS rise SHALL take priority and the SCLK edge SHALL be ignored.
REQ-025 A CS rise coinciding with WR_COMMIT SHALL still complete that commit, because the word is already whole.
REQ-026 Address wrap-around: the counter at 2**ADDR_WIDTH-1 SHALL wrap to 0 in both burst directions, with no error indication.
REQ-027 While cs_pin is high, SCLK and MOSI activity SHALL have no effect.

Reset
REQ-028 On reset high at a clk edge: state=IDLE, miso_pin=0, miso_oe=0, leds=4'b0000, counters and shift register cleared, and synchronizer flops set to the idle line levels (CS=1, SCLK=0, MOSI=0).
REQ-029 Memory contents SHALL NOT be altered by reset.
REQ-030 Reset asserted mid-transaction SHALL abort it like REQ-023. Any write not yet in WR_COMMIT SHALL be lost.
REQ-031 After reset releases, a transaction SHALL start only on a fresh CS fall; a CS held low through reset SHALL be ignored until it rises and falls again.

Verification
REQ-032 Single write then read: write 0xA5 to address 0x12 (frame 0x24); a later read frame 0x25 -> miso shows 0xA5 MSB first with miso_oe high; leds[3] toggles once.
REQ-033 Burst write with wrap: start at 0x7F and send 0x11, 0x22, 0x33 -> mem[0x7F]=0x11, mem[0x00]=0x22, mem[0x01]=0x33; leds[3] toggles 3 times.
REQ-034 Burst read: after REQ-033, read from 0x7F for 24 SCLKs -> MISO returns 0x11, 0x22, 0x33 with no gap bits.
REQ-035 CS abort: write to 0x05 (previously 0x3C), raise CS after 5 data bits -> mem[0x05] stays 0x3C, state IDLE, miso_oe=0 within SYNC_STAGES+2 clk.
REQ-036 Reset mid-read: assert reset during bit 3 of a read word -> next clk miso_oe=0, miso_pin=0, leds=0. Memory is unchanged, and a following CS fall-and-rise-free sequence produces no activity.
REQ-037 Parameter sweep: repeat REQ-032 and REQ-033 with ADDR_WIDTH=4, DATA_WIDTH=16; wrap SHALL occur at 0xF -> 0x0.

Source files
------------

// File: rtl/spi_burst_memory.sv
// SPI mode-0 slave giving burst read/write access to an on-chip word memory.
// Command frame is {address, R/W} MSB first; data words follow back to back,
// the address counter advancing (and wrapping) after every word.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a fresh CS fall
// CMD       | shifting in {address, R/W}
// RD_LOAD   | two-clk memory fetch into the shift register
// RD_SHIFT  | driving the read word on MISO, one bit per SCLK fall
// WR_SHIFT  | shifting in a write word from MOSI
// WR_COMMIT | one-clk write of the received word, address advance
module spi_burst_memory #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic [3:0] leds
);
    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int MAX_BITS = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CNT_W    = $clog2(MAX_BITS);
    localparam int FLUSH_W  = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0]   CMD_LAST   = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        IDLE, CMD, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  cs_sync, sclk_sync, mosi_sync;
    logic                    cs_d, sclk_d, mosi_d;
    logic                    cs_s, sclk_s;
    logic                    cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [FLUSH_W-1:0]      flush_cnt;
    logic                    armed;
    logic [CNT_W-1:0]        bit_cnt;
    logic [ADDR_WIDTH-1:0]   cmd_sr;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   shift_sr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    load_wait;
    logic                    led_commit;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // Synchronize the SPI pins and keep one extra flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
            mosi_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    // Arm only after the synchronizer has flushed and CS is seen high, so a
    // CS held low through reset cannot look like a fresh fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= FLUSH_INIT;
            armed     <= 1'b0;
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 1'b1;
        end else if (cs_s && cs_d) begin
            armed <= 1'b1;
        end
    end

    // Transaction FSM; a CS rise outranks any SCLK edge seen in the same clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            addr       <= '0;
            shift_sr   <= '0;
            load_wait  <= 1'b0;
            miso_pin   <= 1'b0;
            miso_oe    <= 1'b0;
            led_commit <= 1'b0;
        end else if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            miso_oe <= 1'b0;
            if (state == WR_COMMIT) begin
                addr       <= addr + 1'b1;
                led_commit <= ~led_commit;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall && armed) begin
                        state   <= CMD;
                        bit_cnt <= '0;
                        miso_oe <= 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_sr <= {cmd_sr[ADDR_WIDTH-2:0], mosi_d};
                        if (bit_cnt == CMD_LAST) begin
                            addr      <= cmd_sr;
                            bit_cnt   <= '0;
                            load_wait <= 1'b0;
                            state     <= mosi_d ? RD_LOAD : WR_SHIFT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                RD_LOAD: begin
                    if (!load_wait) begin
                        load_wait <= 1'b1;
                    end else begin
                        load_wait <= 1'b0;
                        shift_sr  <= rd_data;
                        miso_oe   <= 1'b1;
                        state     <= RD_SHIFT;
                    end
                end
                RD_SHIFT: begin
                    if (sclk_fall) begin
                        miso_pin <= shift_sr[DATA_WIDTH-1];
                        shift_sr <= {shift_sr[DATA_WIDTH-2:0], 1'b0};
                    end else if (sclk_rise) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            addr    <= addr + 1'b1;
                            state   <= RD_LOAD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                WR_SHIFT: begin
                    if (sclk_rise) begin
                        shift_sr <= {shift_sr[DATA_WIDTH-2:0], mosi_d};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= WR_COMMIT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                WR_COMMIT: begin
                    addr       <= addr + 1'b1;
                    led_commit <= ~led_commit;
                    state      <= WR_SHIFT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory array: not reset; a commit already in progress still lands.
    always_ff @(posedge clk) begin
        rd_data <= mem[addr];
        if (state == WR_COMMIT) begin
            mem[addr] <= shift_sr;
        end
    end

    assign leds = {led_commit,
                   (state == WR_SHIFT) || (state == WR_COMMIT),
                   (state == RD_LOAD)  || (state == RD_SHIFT),
                   state != IDLE};

endmodule
